zero_pattern_gen: RTL and testbench

ZERO_PATTERN_GEN -- requirements
Module: zero_pattern_gen

---
 rtl/zero_pattern_gen.sv | 147 ++++++++++++++
 tb/tb_zero_pattern_gen.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/zero_pattern_gen.sv
// Walks a fixed 13-vector table into a zero detector and scores its replies.
// Optional: define ZPG_FIRST_FAIL_EN to add the first_fail index output.
module zero_pattern_gen #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       is_zero,
  output logic [7:0] n,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
`ifdef ZPG_FIRST_FAIL_EN
  output logic [3:0] first_fail,
`endif
  output logic [3:0] vec_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] LP_LAST_CNT = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] LP_LAST_IDX = 4'd12;

  function automatic logic [7:0] vec_lut(input logic [3:0] i);
    logic [7:0] v;
    case (i)
      4'd0:    v = 8'h01;
      4'd1:    v = 8'h02;
      4'd2:    v = 8'h04;
      4'd3:    v = 8'h08;
      4'd4:    v = 8'h10;
      4'd5:    v = 8'h20;
      4'd6:    v = 8'h40;
      4'd7:    v = 8'h80;
      4'd9:    v = 8'hAA;
      4'd10:   v = 8'h55;
      4'd11:   v = 8'hFF;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  state_t     r_state;
  logic [7:0] r_n;
  logic [3:0] r_cnt;
  logic [3:0] r_idx;
  logic [3:0] r_err;

  state_t     w_state_nx;
  logic [7:0] w_n_nx;
  logic [3:0] w_cnt_nx;
  logic [3:0] w_idx_nx;
  logic [3:0] w_err_nx;
  logic       w_sample;
  logic       w_expect;
  logic       w_miss;
  logic       w_launch;

  assign w_sample = (r_state == S_DRIVE) && (r_cnt == LP_LAST_CNT);
  assign w_expect = (r_idx == 4'd8) || (r_idx == LP_LAST_IDX);
  assign w_miss   = w_sample && (is_zero != w_expect);
  assign w_launch = start && (r_state != S_DRIVE);

  always_comb begin
    w_state_nx = r_state;
    w_n_nx     = r_n;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_err_nx   = r_err;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nx = S_DRIVE;
          w_n_nx     = vec_lut(4'd0);
          w_cnt_nx   = 4'd0;
          w_idx_nx   = 4'd0;
          w_err_nx   = 4'd0;
        end
      end
      S_DRIVE: begin
        w_cnt_nx = r_cnt + 4'd1;
        if (w_miss) w_err_nx = r_err + 4'd1;
        if (w_sample) begin
          w_cnt_nx = 4'd0;
          if (r_idx == LP_LAST_IDX) begin
            w_state_nx = S_DONE;
            w_n_nx     = 8'h00;
          end else begin
            w_idx_nx = r_idx + 4'd1;
            w_n_nx   = vec_lut(r_idx + 4'd1);
          end
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_n_nx     = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_n     <= 8'h00;
      r_cnt   <= 4'd0;
      r_idx   <= 4'd0;
      r_err   <= 4'd0;
    end else begin
      r_state <= w_state_nx;
      r_n     <= w_n_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_err   <= w_err_nx;
    end
  end

`ifdef ZPG_FIRST_FAIL_EN
  logic [3:0] r_first_fail;

  // 4'hF cannot be a vector index, so it doubles as "nothing failed yet"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first_fail <= 4'hF;
    end else if (w_launch) begin
      r_first_fail <= 4'hF;
    end else if (w_miss && (r_first_fail == 4'hF)) begin
      r_first_fail <= r_idx;
    end
  end

  assign first_fail = r_first_fail;
`endif

  assign n         = r_n;
  assign busy      = (r_state == S_DRIVE);
  assign done      = (r_state == S_DONE);
  assign pass      = done && (r_err == 4'd0);
  assign err_count = r_err;
  assign vec_idx   = r_idx;

endmodule

// File: tb/tb_zero_pattern_gen.sv
// Scoreboard bench: stimulus queues expected run results, monitor scores them.
module tb_zero_pattern_gen;

  localparam int HOLD = 4;

  typedef struct {
    logic       pass;
    logic [3:0] err;
    logic [3:0] ff;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       is_zero;
  logic [7:0] n;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [3:0] vec_idx;
`ifdef ZPG_FIRST_FAIL_EN
  logic [3:0] first_fail;
`endif

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  exp_t sb_q[$];
  logic [7:0] tbl [13];

  zero_pattern_gen #(.HOLD_CYCLES(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_zero   (is_zero),
    .n         (n),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
`ifdef ZPG_FIRST_FAIL_EN
    .first_fail(first_fail),
`endif
    .vec_idx   (vec_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Detector models: 0 correct, 1 stuck 0, 2 stuck 1, 3 blind to bit 7
  always_comb begin
    is_zero = 1'b0;
    case (mode)
      0: is_zero = (n == 8'h00);
      1: is_zero = 1'b0;
      2: is_zero = 1'b1;
      3: is_zero = (n[6:0] == 7'h00);
      default: is_zero = 1'b0;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: per-cycle sequence check and end-of-run scoring
  int  k = -1;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      k = -1;
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (busy) begin
        k = prev_busy ? k + 1 : 0;
        if (k < 13 * HOLD) begin
          chk("seq_n", n, tbl[k / HOLD]);
          chk("seq_idx", vec_idx, k / HOLD);
        end else begin
          chk("run_overlong", k, 13 * HOLD - 1);
        end
      end
      if (done && !prev_done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("run_len", k + 1, 13 * HOLD);
          chk("pass", pass, e.pass);
          chk("err_count", err_count, e.err);
          chk("done_idx", vec_idx, 12);
          chk("done_n", n, 0);
`ifdef ZPG_FIRST_FAIL_EN
          chk("first_fail", first_fail, e.ff);
`endif
        end
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic launch(input int m, input logic p,
                        input logic [3:0] e, input logic [3:0] f);
    exp_t x;
    x.pass = p;
    x.err  = e;
    x.ff   = f;
    mode = m;
    sb_q.push_back(x);
    pulse_start();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic wait_idx(input logic [3:0] want);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (vec_idx == want && busy) return;
    end
    chk("idx_timeout", 0, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_n"}, n, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_idx"}, vec_idx, 0);
`ifdef ZPG_FIRST_FAIL_EN
    chk({tag, "_ff"}, first_fail, 4'hF);
`endif
  endtask

  initial begin
    tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
            8'h80, 8'h00, 8'hAA, 8'h55, 8'hFF, 8'h00};
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);

    launch(0, 1'b1, 4'd0, 4'hF);
    wait_done();

    launch(2, 1'b0, 4'd11, 4'd0);
    wait_done();

    // restart from DONE must clear err_count and drop done
    launch(1, 1'b0, 4'd2, 4'd8);
    chk("restart_done", done, 0);
    chk("restart_err", err_count, 0);
    chk("restart_busy", busy, 1);
    wait_done();

    launch(3, 1'b0, 4'd1, 4'd7);
    wait_done();

    // start while busy is ignored
    launch(0, 1'b1, 4'd0, 4'hF);
    wait_idx(4'd3);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_restart_idx", vec_idx, 3);
    wait_done();

    // async reset mid-hold aborts the run without done
    mode = 0;
    pulse_start();
    wait_idx(4'd5);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_idle", busy, 0);
    chk("post_rst_done", done, 0);
    launch(0, 1'b1, 4'd0, 4'hF);
    wait_done();

    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
